// File: rtl/angle_gen_pkg.sv
// Shared definitions for the multi-channel NCO that feeds the rotation-mode CORDIC:
// default start magnitude, config-target encodings and the output FSM states.
package angle_gen_pkg;

    localparam int AN_DEFAULT = 1215;

    localparam logic CFG_FREQ   = 1'b0;
    localparam logic CFG_OFFSET = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/angle_fold.sv
// Folds a full-circle phase into the CORDIC range [-pi/2, pi/2) and picks the
// start vector sign that compensates for the pi rotation.
module angle_fold
    import angle_gen_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int AN    = AN_DEFAULT
) (
    input  logic [WIDTH-1:0] phase,
    output logic [WIDTH-1:0] angle,
    output logic [WIDTH-1:0] x_start
);

    localparam logic [WIDTH-1:0] AN_POS = WIDTH'(AN);
    localparam logic [WIDTH-1:0] AN_NEG = WIDTH'(-AN);

    logic flip;

    // Top two bits differing means the phase lies in the left half-plane.
    assign flip    = phase[WIDTH-1] ^ phase[WIDTH-2];
    assign angle   = flip ? {~phase[WIDTH-1], phase[WIDTH-2:0]} : phase;
    assign x_start = flip ? AN_NEG : AN_POS;

endmodule

// File: rtl/angle_gen_nco.sv
// Time-multiplexed per-channel phase accumulators with offsets, emitting one
// folded CORDIC start sample per valid/ready transfer in round-robin order.
module angle_gen_nco
    import angle_gen_pkg::*;
#(
    parameter int  WIDTH     = 12,
    parameter int  ACC_WIDTH = 24,
    parameter int  NCH       = 4,
    parameter int  AN        = AN_DEFAULT,
    localparam int CH_W      = $clog2(NCH)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [ACC_WIDTH-1:0] cfg_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_last,
    output logic [WIDTH-1:0]     angle,
    output logic [WIDTH-1:0]     x_start,
    output logic [WIDTH-1:0]     y_start
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    state_t                 state;
    logic [CH_W-1:0]        ptr;
    logic [ACC_WIDTH-1:0]   acc    [NCH];
    logic [ACC_WIDTH-1:0]   freq   [NCH];
    logic [WIDTH-1:0]       offset [NCH];

    logic                   handshake;
    logic                   do_load;
    logic                   cfg_hit;
    logic [CH_W-1:0]        next_ptr;
    logic [CH_W-1:0]        load_ch;
    logic [WIDTH-1:0]       load_phase;
    logic [WIDTH-1:0]       fold_angle;
    logic [WIDTH-1:0]       fold_x;

    assign handshake = (state == FULL) && out_ready;
    assign next_ptr  = (ptr == LAST_CH) ? '0 : ptr + 1'b1;
    // On an accept the next sample belongs to the channel after the one leaving.
    assign load_ch   = handshake ? next_ptr : ptr;
    assign do_load   = enable && ((state == EMPTY) || handshake);
    assign cfg_hit   = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(NCH));

    assign load_phase = acc[load_ch][ACC_WIDTH-1 -: WIDTH] + offset[load_ch];

    angle_fold #(
        .WIDTH (WIDTH),
        .AN    (AN)
    ) u_fold (
        .phase   (load_phase),
        .angle   (fold_angle),
        .x_start (fold_x)
    );

    assign out_valid = (state == FULL);
    assign y_start   = '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_ch   <= '0;
            out_last <= 1'b0;
            angle    <= '0;
            x_start  <= '0;
            // NOTE: the config and accumulator arrays are reset too, because every
            // channel must restart from phase 0 with a known frequency and offset.
            for (int i = 0; i < NCH; i++) begin
                acc[i]    <= '0;
                freq[i]   <= '0;
                offset[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates mean a same-edge config write cannot leak
            // into this edge's accumulate or load; both see the pre-edge values.
            if (handshake) begin
                acc[ptr] <= acc[ptr] + freq[ptr];
                ptr      <= next_ptr;
            end

            if (cfg_hit) begin
                if (cfg_sel == CFG_FREQ) begin
                    freq[cfg_ch] <= cfg_data;
                end else begin
                    offset[cfg_ch] <= cfg_data[WIDTH-1:0];
                end
            end

            if (do_load) begin
                state    <= FULL;
                out_ch   <= load_ch;
                out_last <= (load_ch == LAST_CH);
                angle    <= fold_angle;
                x_start  <= fold_x;
            end else if (handshake) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_angle_gen_nco.sv
// Self-checking bench for angle_gen_nco: directed literal checks plus a randomized
// run compared every cycle against an arithmetic reference model.
module tb_angle_gen_nco;
    import angle_gen_pkg::*;

    localparam int W  = 12;
    localparam int AW = 24;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic          clock = 1'b0;
    logic          resetn;
    logic          enable, cfg_we, cfg_sel, out_ready;
    logic [1:0]    cfg_ch;
    logic [AW-1:0] cfg_data;
    logic          out_valid, out_last;
    logic [1:0]    out_ch;
    logic [W-1:0]  angle, x_start, y_start;

    logic          en3, we3, sel3, rdy3;
    logic [1:0]    ch3w;
    logic [AW-1:0] data3;
    logic          v3, last3;
    logic [1:0]    ch3o;
    logic [W-1:0]  ang3, x3, y3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    angle_gen_nco #(.WIDTH(W), .ACC_WIDTH(AW), .NCH(N), .AN(1215)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_last(out_last), .angle(angle), .x_start(x_start), .y_start(y_start)
    );

    angle_gen_nco #(.WIDTH(W), .ACC_WIDTH(AW), .NCH(N3), .AN(1215)) dut3 (
        .clock(clock), .resetn(resetn), .enable(en3), .cfg_we(we3),
        .cfg_sel(sel3), .cfg_ch(ch3w), .cfg_data(data3),
        .out_valid(v3), .out_ready(rdy3), .out_ch(ch3o),
        .out_last(last3), .angle(ang3), .x_start(x3), .y_start(y3)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: phase arithmetic done on plain integers, fold decided by range.
    function automatic void fold_ref(input int p, output int a, output int x);
        int s;
        s = (p >= 2048) ? p - 4096 : p;
        if (s >= -1024 && s < 1024) begin
            a = p;
            x = 1215;
        end else begin
            a = (p + 2048) % 4096;
            x = 4096 - 1215;
        end
    endfunction

    int m_acc [N] = '{default: 0};
    int m_freq[N] = '{default: 0};
    int m_off [N] = '{default: 0};
    int m_ptr   = 0;
    bit m_full  = 0;
    int m_ch    = 0;
    bit m_last  = 0;
    int m_angle = 0;
    int m_x     = 0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_acc[i] = 0; m_freq[i] = 0; m_off[i] = 0;
            end
            m_ptr = 0; m_full = 0; m_ch = 0; m_last = 0; m_angle = 0; m_x = 0;
        end else begin
            bit hs, ld;
            int lc, p, a, x;
            hs = m_full && out_ready;
            lc = hs ? (m_ptr + 1) % N : m_ptr;
            ld = enable && (!m_full || hs);
            if (ld) begin
                p = ((m_acc[lc] >> (AW - W)) + m_off[lc]) % 4096;
                fold_ref(p, a, x);
                m_angle = a; m_x = x; m_ch = lc; m_last = (lc == N - 1);
            end
            if (hs) begin
                m_acc[m_ptr] = (m_acc[m_ptr] + m_freq[m_ptr]) & 24'hFFFFFF;
                m_ptr = lc;
            end
            m_full = ld ? 1'b1 : (hs ? 1'b0 : m_full);
            if (cfg_we) begin
                if (cfg_sel == CFG_FREQ) m_freq[cfg_ch] = int'(cfg_data);
                else                     m_off[cfg_ch]  = int'(cfg_data[W-1:0]);
            end
        end
    end

    always @(negedge clock) begin
        check("model_valid", out_valid, m_full);
        check("model_y", y_start, 0);
        if (m_full) begin
            check("model_ch", out_ch, m_ch);
            check("model_last", out_last, m_last);
            check("model_angle", angle, m_angle);
            check("model_x", x_start, m_x);
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic cfg_write(input logic sel, input int ch, input int data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_ch = 2'(ch); cfg_data = AW'(data);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wait_ch(input int ch);
        bit ok;
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            if (out_valid && out_ch == 2'(ch)) begin
                ok = 1;
                break;
            end
            step();
        end
        check("wait_ch", ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int     k;
    int     sw_a[17] = '{default: 0};
    int     sw_x[17] = '{default: 0};
    logic [W-1:0] ha, hx;

    initial begin
        resetn = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
        cfg_ch = '0; cfg_data = '0; out_ready = 1'b0;
        en3 = 1'b0; we3 = 1'b0; sel3 = 1'b0; ch3w = '0; data3 = '0; rdy3 = 1'b0;
        #1 resetn = 1'b0;
        step(); step();
        check("rst_valid", out_valid, 0);
        check("rst_ch", out_ch, 0);
        check("rst_last", out_last, 0);
        check("rst_angle", angle, 0);
        check("rst_x", x_start, 0);
        check("rst_y", y_start, 0);
        check("rst3_valid", v3, 0);
        resetn = 1'b1;

        // Round robin with all frequencies zero.
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("rr_valid", out_valid, 1);
            check("rr_ch", out_ch, i % N);
            check("rr_last", out_last, (i % N) == N - 1);
            check("rr_angle", angle, 0);
            check("rr_x", x_start, 12'h4BF);
        end

        // Phase sweep on channel 0 in pi/8 steps.
        enable = 1'b0; step(); step();
        cfg_write(CFG_FREQ, 0, 24'h100000);
        enable = 1'b1; k = 0;
        for (int i = 0; i < 200 && k < 17; i++) begin
            step();
            if (out_valid && out_ch == 2'd0) begin
                sw_a[k] = int'(angle); sw_x[k] = int'(x_start); k++;
            end
        end
        check("sweep_count", k, 17);
        for (int j = 0; j < 4; j++) begin
            check("sweep_a_q0", sw_a[j], j * 256);
            check("sweep_x_q0", sw_x[j], 12'h4BF);
        end
        check("sweep_a_400", sw_a[4], 12'hC00);
        check("sweep_x_400", sw_x[4], 12'hB41);
        check("sweep_a_800", sw_a[8], 12'h000);
        check("sweep_x_800", sw_x[8], 12'hB41);
        check("sweep_a_C00", sw_a[12], 12'hC00);
        check("sweep_x_C00", sw_x[12], 12'h4BF);
        check("sweep_a_wrap", sw_a[16], 12'h000);
        check("sweep_x_wrap", sw_x[16], 12'h4BF);

        // Backpressure on channel 2 with enable dropped.
        wait_ch(2);
        out_ready = 1'b0; enable = 1'b0; ha = angle; hx = x_start;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_ch", out_ch, 2);
            check("bp_angle", angle, ha);
            check("bp_x", x_start, hx);
        end
        out_ready = 1'b1;
        step();
        check("bp_drain", out_valid, 0);

        // Channel 1 offset of pi/2.
        cfg_write(CFG_OFFSET, 1, 24'h000400);
        enable = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_ch(1);
            check("off_angle", angle, 12'hC00);
            check("off_x", x_start, 12'hB41);
            step();
        end

        // Asynchronous reset while full and stalled.
        out_ready = 1'b0; step(); step();
        check("pre_rst_valid", out_valid, 1);
        #1 resetn = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_angle", angle, 0);
        @(posedge clock); #2 resetn = 1'b1; out_ready = 1'b1;
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_ch", out_ch, 0);
        check("post_rst_angle", angle, 0);
        check("post_rst_x", x_start, 12'h4BF);

        // Frequency write racing a channel 0 accept.
        enable = 1'b0; step(); step();
        cfg_write(CFG_FREQ, 0, 24'h100000);
        enable = 1'b1;
        wait_ch(0);
        check("race_a0", angle, 12'h000);
        cfg_we = 1'b1; cfg_sel = CFG_FREQ; cfg_ch = 2'd0; cfg_data = 24'h200000;
        step();
        cfg_we = 1'b0;
        wait_ch(0);
        check("race_a1", angle, 12'h100);
        step();
        wait_ch(0);
        check("race_a2", angle, 12'h300);

        // Randomized traffic and configuration.
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_we    = ($urandom_range(0, 4) == 0);
            cfg_sel   = ($urandom_range(0, 1) == 1);
            cfg_ch    = 2'($urandom_range(0, N - 1));
            cfg_data  = AW'($urandom);
            step();
        end
        cfg_we = 1'b0;

        // Three-channel instance: a write to channel 3 does not exist.
        we3 = 1'b1; sel3 = CFG_FREQ; ch3w = 2'd3; data3 = 24'h400000;
        step();
        sel3 = CFG_OFFSET; data3 = 24'h000400;
        step();
        we3 = 1'b0; en3 = 1'b1; rdy3 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("n3_valid", v3, 1);
            check("n3_ch", ch3o, i % N3);
            check("n3_last", last3, (i % N3) == N3 - 1);
            check("n3_angle", ang3, 0);
            check("n3_x", x3, 12'h4BF);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
